// File: rtl/data_mem_ctrl_if.sv
// Request/response bus between a MEM-stage master and data_mem_ctrl.
// Optional parity signals exist only when MEM_PARITY_EN is defined.
interface data_mem_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  localparam int NB = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [NB-1:0]     req_be;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              init_done;
`ifdef MEM_PARITY_EN
  logic              inj_perr;
  logic              rsp_perr;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, inj_perr,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, init_done, rsp_perr
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, inj_perr,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, init_done, rsp_perr
  );
`else
  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
  );
`endif
endinterface

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: single-port data memory with valid/ready request port and a
// registered one-cycle response. Byte strobes, alignment/range checking and a
// post-reset clear sweep (INIT) before requests are accepted.
// Optional feature macro: MEM_PARITY_EN (per-byte even parity, inj_perr/rsp_perr).
module data_mem_ctrl #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  data_mem_ctrl_if.slave bus
);
  localparam int NB    = DATA_W / 8;
  localparam int LG_NB = (NB > 1) ? $clog2(NB) : 0;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t            r_state;
  logic [IDX_W-1:0]  r_cnt;
  logic              r_ready;
  logic              r_init_done;
  logic              r_rsp_valid;
  logic              r_rsp_err;
  logic              r_rsp_rd;      // response carries read data
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_q;        // RAM output register

  logic              w_accept;
  logic [ADDR_W-1:0] w_idx;
  logic              w_err;
  logic [IDX_W-1:0]  w_ram_idx;
  logic              w_mem_we;
  logic              w_mem_re;
  logic [NB-1:0]     w_mem_be;
  logic [IDX_W-1:0]  w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;

  assign w_accept  = bus.req_valid & r_ready;
  assign w_idx     = bus.req_addr >> LG_NB;
  // Full-width compare: any index at or past DEPTH errors, never wraps.
  assign w_err     = (|(bus.req_addr & ADDR_W'(NB - 1))) | (w_idx >= ADDR_W'(DEPTH));
  assign w_ram_idx = w_idx[IDX_W-1:0];
  assign w_mem_re  = w_accept & ~bus.req_we & ~w_err;

  // Write port: INIT clear sweep owns the port until RUN, then accepted writes.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_be    = '0;
    w_mem_addr  = w_ram_idx;
    w_mem_wdata = bus.req_wdata;
    if (r_state == ST_INIT) begin
      w_mem_we    = 1'b1;
      w_mem_be    = '1;
      w_mem_addr  = r_cnt;
      w_mem_wdata = '0;
    end else begin
      w_mem_we = w_accept & bus.req_we & ~w_err;
      w_mem_be = bus.req_be;
    end
  end

`ifdef MEM_PARITY_EN
  logic [NB-1:0] r_par [DEPTH];
  logic [NB-1:0] r_par_q;
  logic [NB-1:0] w_wr_par;
  logic [NB-1:0] w_rd_par;
  logic          w_inj;

  // Injection only applies to real requests, never to the clear sweep.
  assign w_inj = (r_state == ST_RUN) & bus.inj_perr;

  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_par
      assign w_wr_par[gi] = (^w_mem_wdata[gi*8 +: 8]) ^ w_inj;
      assign w_rd_par[gi] = ^r_rd_q[gi*8 +: 8];
    end
  endgenerate

  // Parity store alongside the data RAM, same strobes and registered read.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int b = 0; b < NB; b++) begin
        if (w_mem_be[b]) r_par[w_mem_addr][b] <= w_wr_par[b];
      end
    end
    if (w_mem_re) r_par_q <= r_par[w_ram_idx];
  end

  assign bus.rsp_perr = r_rsp_rd & (w_rd_par != r_par_q);
`endif

  // Data RAM: byte-masked write, registered read (no reset so it maps to block RAM).
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int b = 0; b < NB; b++) begin
        if (w_mem_be[b]) r_mem[w_mem_addr][b*8 +: 8] <= w_mem_wdata[b*8 +: 8];
      end
    end
    if (w_mem_re) r_rd_q <= r_mem[w_ram_idx];
  end

  // Control FSM: DEPTH-cycle clear sweep, then RUN with ready/init_done held high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_INIT;
      r_cnt       <= '0;
      r_ready     <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == IDX_W'(DEPTH - 1)) begin
            r_state     <= ST_RUN;
            r_ready     <= 1'b1;
            r_init_done <= 1'b1;
          end
        end
        default: begin
          r_ready     <= 1'b1;
          r_init_done <= 1'b1;
        end
      endcase
    end
  end

  // Response pipeline: one pulse per accept, flags cleared when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rd    <= 1'b0;
    end else begin
      r_rsp_valid <= w_accept;
      r_rsp_err   <= w_accept & w_err;
      r_rsp_rd    <= w_mem_re;
    end
  end

  assign bus.req_ready = r_ready;
  assign bus.init_done = r_init_done;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.rsp_rdata = r_rsp_rd ? r_rd_q : '0;
endmodule
